// File: rtl/mic1_mem_arbiter.sv
// Shares one single-port synchronous RAM between the MIC1 data path (MAR/MDR)
// and instruction fetch (PC/MBR), stalling the core while an access is in flight.
module mic1_mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int LAT    = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rd,
    input  logic              wr,
    input  logic              fetch,
    input  logic [31:0]       mar,
    input  logic [31:0]       mdr_out,
    input  logic [31:0]       pc,
    output logic              mem_req,
    output logic              mem_wren,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       mdr_in,
    output logic              mdr_load,
    output logic [7:0]        mbr_in,
    output logic              mbr_load,
    output logic              stall,
    output logic              err
);

    typedef enum logic [2:0] {IDLE, D_ISSUE, D_WAIT, F_ISSUE, F_WAIT} state_t;

    localparam logic [2:0] CNT_LAST = 3'(LAT - 1);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] mar_reg;
    logic [ADDR_W-1:0] pc_word_reg;
    logic [1:0]        byte_sel_reg;
    logic [31:0]       wdata_reg;
    logic              wr_reg;
    logic              fetch_reg;
    logic [2:0]        cnt_reg;
    logic              wait_done;
    logic              take;
    logic              unused_bits;

    // Only the word-address bits reach the memory; the rest wrap away.
    assign unused_bits = &{1'b0, mar[31:ADDR_W], pc[31:ADDR_W+2]};

    assign wait_done = (cnt_reg == CNT_LAST);
    assign take      = (state_reg == IDLE) && (rd || wr || fetch);
    assign mem_wdata = wdata_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (rd || wr)
                    state_next = D_ISSUE;
                else if (fetch)
                    state_next = F_ISSUE;
            end
            D_ISSUE: begin
                if (!wr_reg)
                    state_next = D_WAIT;
                else
                    state_next = fetch_reg ? F_ISSUE : IDLE;
            end
            D_WAIT: begin
                if (wait_done)
                    state_next = fetch_reg ? F_ISSUE : IDLE;
            end
            F_ISSUE: state_next = F_WAIT;
            F_WAIT: begin
                if (wait_done)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        stall    = (state_reg != IDLE);
        mem_req  = (state_reg == D_ISSUE) || (state_reg == F_ISSUE);
        mem_wren = (state_reg == D_ISSUE) && wr_reg;
        mem_addr = (state_reg == F_ISSUE) ? pc_word_reg : mar_reg;
    end

    // A read sampled together with a write is dropped; wr_reg alone decides.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mar_reg      <= '0;
            pc_word_reg  <= '0;
            byte_sel_reg <= '0;
            wdata_reg    <= '0;
            wr_reg       <= 1'b0;
            fetch_reg    <= 1'b0;
            cnt_reg      <= '0;
            mdr_in       <= '0;
            mdr_load     <= 1'b0;
            mbr_in       <= '0;
            mbr_load     <= 1'b0;
            err          <= 1'b0;
        end else begin
            err      <= take && rd && wr;
            mdr_load <= 1'b0;
            mbr_load <= 1'b0;
            if (take) begin
                mar_reg      <= mar[ADDR_W-1:0];
                pc_word_reg  <= pc[ADDR_W+1:2];
                byte_sel_reg <= pc[1:0];
                wdata_reg    <= mdr_out;
                wr_reg       <= wr;
                fetch_reg    <= fetch;
            end
            if (state_reg == D_WAIT || state_reg == F_WAIT)
                cnt_reg <= cnt_reg + 3'd1;
            else
                cnt_reg <= '0;
            if (state_reg == D_WAIT && wait_done) begin
                mdr_in   <= mem_rdata;
                mdr_load <= 1'b1;
            end
            if (state_reg == F_WAIT && wait_done) begin
                mbr_load <= 1'b1;
                case (byte_sel_reg)
                    2'd0:    mbr_in <= mem_rdata[7:0];
                    2'd1:    mbr_in <= mem_rdata[15:8];
                    2'd2:    mbr_in <= mem_rdata[23:16];
                    default: mbr_in <= mem_rdata[31:24];
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mic1_mem_arbiter.sv
// Directed bench for mic1_mem_arbiter: one instance with LAT=1 and one with
// LAT=2 share stimulus, each backed by its own small latency-accurate RAM.
module tb_mic1_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rd = 1'b0, wr = 1'b0, fetch = 1'b0;
    logic [31:0] mar = '0, mdr_out = '0, pc = '0;

    logic        req1, wren1, mdrl1, mbrl1, stall1, err1;
    logic [15:0] addr1;
    logic [31:0] wdata1, rdata1, mdrin1;
    logic [7:0]  mbrin1;
    logic        req2, wren2, mdrl2, mbrl2, stall2, err2;
    logic [15:0] addr2;
    logic [31:0] wdata2, rdata2, mdrin2;
    logic [7:0]  mbrin2;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    mic1_mem_arbiter #(.ADDR_W(16), .LAT(1)) u1 (
        .clock(clock), .reset(reset), .rd(rd), .wr(wr), .fetch(fetch),
        .mar(mar), .mdr_out(mdr_out), .pc(pc),
        .mem_req(req1), .mem_wren(wren1), .mem_addr(addr1), .mem_wdata(wdata1),
        .mem_rdata(rdata1), .mdr_in(mdrin1), .mdr_load(mdrl1),
        .mbr_in(mbrin1), .mbr_load(mbrl1), .stall(stall1), .err(err1)
    );

    mic1_mem_arbiter #(.ADDR_W(16), .LAT(2)) u2 (
        .clock(clock), .reset(reset), .rd(rd), .wr(wr), .fetch(fetch),
        .mar(mar), .mdr_out(mdr_out), .pc(pc),
        .mem_req(req2), .mem_wren(wren2), .mem_addr(addr2), .mem_wdata(wdata2),
        .mem_rdata(rdata2), .mdr_in(mdrin2), .mdr_load(mdrl2),
        .mbr_in(mbrin2), .mbr_load(mbrl2), .stall(stall2), .err(err2)
    );

    // RAM models: read data appears LAT cycles after the request cycle.
    logic [31:0] mem1 [0:15];
    logic [31:0] mem2 [0:15];
    logic [31:0] rp1, rp2a, rp2b;
    assign rdata1 = rp1;
    assign rdata2 = rp2b;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem1[1] <= 32'h11CA_2233;
            mem1[5] <= 32'h0000_0033;
            rp1     <= '0;
        end else begin
            if (req1 && wren1) mem1[addr1[3:0]] <= wdata1;
            if (req1 && !wren1) rp1 <= mem1[addr1[3:0]];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem2[1] <= 32'h11CA_2233;
            mem2[5] <= 32'h0000_0033;
            rp2a    <= '0;
            rp2b    <= '0;
        end else begin
            if (req2 && wren2) mem2[addr2[3:0]] <= wdata2;
            if (req2 && !wren2) rp2a <= mem2[addr2[3:0]];
            rp2b <= rp2a;
        end
    end

    // Per-cycle logs, index [instance][cycle], cycle 0 = request sampled.
    logic        lreq   [1:2][0:15];
    logic        lwren  [1:2][0:15];
    logic        lstall [1:2][0:15];
    logic        lmdrl  [1:2][0:15];
    logic        lmbrl  [1:2][0:15];
    logic        lerr   [1:2][0:15];
    logic [15:0] laddr  [1:2][0:15];
    logic [31:0] lmdrin [1:2][0:15];
    logic [7:0]  lmbrin [1:2][0:15];

    task automatic capture(input int c);
        lreq[1][c] = req1;     lreq[2][c] = req2;
        lwren[1][c] = wren1;   lwren[2][c] = wren2;
        lstall[1][c] = stall1; lstall[2][c] = stall2;
        lmdrl[1][c] = mdrl1;   lmdrl[2][c] = mdrl2;
        lmbrl[1][c] = mbrl1;   lmbrl[2][c] = mbrl2;
        lerr[1][c] = err1;     lerr[2][c] = err2;
        laddr[1][c] = addr1;   laddr[2][c] = addr2;
        lmdrin[1][c] = mdrin1; lmdrin[2][c] = mdrin2;
        lmbrin[1][c] = mbrin1; lmbrin[2][c] = mbrin2;
    endtask

    task automatic start(input logic r, input logic w, input logic f,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] p, input int n);
        @(negedge clock);
        rd = r; wr = w; fetch = f; mar = a; mdr_out = d; pc = p;
        @(posedge clock);
        #1 rd = 1'b0; wr = 1'b0; fetch = 1'b0;
        for (int c = 1; c <= n; c++) begin
            @(negedge clock);
            capture(c);
        end
        $display("txn rd=%b wr=%b fetch=%b mar=%h mdr=%h pc=%h", r, w, f, a, d, p);
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clock);
        n_checks++;
        if ({req1, wren1, stall1, mdrl1, mbrl1, err1, addr1, mdrin1, mbrin1, wdata1} !== '0)
            $display("FAIL reset_u1: outputs=%h required 0", {req1, wren1, stall1, mdrl1, mbrl1, err1, addr1, mdrin1, mbrin1, wdata1});
        else n_pass++;
        n_checks++;
        if ({req2, wren2, stall2, mdrl2, mbrl2, err2, addr2, mdrin2, mbrin2, wdata2} !== '0)
            $display("FAIL reset_u2: outputs=%h required 0", {req2, wren2, stall2, mdrl2, mbrl2, err2, addr2, mdrin2, mbrin2, wdata2});
        else n_pass++;
        reset = 1'b0;
        $display("txn reset released");
    endtask

    task automatic test_read;
        start(1'b1, 1'b0, 1'b0, 32'h0000_0005, 32'h0, 32'h0, 9);
        n_checks++; if (lreq[1][1] !== 1'b1 || laddr[1][1] !== 16'd5) $display("FAIL read_req: req=%b addr=%h required 1/0005", lreq[1][1], laddr[1][1]); else n_pass++;
        n_checks++; if (lwren[1][1] !== 1'b0) $display("FAIL read_wren: got %b required 0", lwren[1][1]); else n_pass++;
        n_checks++; if ({lstall[1][1], lstall[1][2], lstall[1][3]} !== 3'b110) $display("FAIL read_stall: c1..3=%b required 110", {lstall[1][1], lstall[1][2], lstall[1][3]}); else n_pass++;
        n_checks++; if ({lmdrl[1][2], lmdrl[1][3], lmdrl[1][4]} !== 3'b010) $display("FAIL read_mdr_load: c2..4=%b required 010", {lmdrl[1][2], lmdrl[1][3], lmdrl[1][4]}); else n_pass++;
        n_checks++; if (lmdrin[1][3] !== 32'h33) $display("FAIL read_mdr_in: got %h required 00000033", lmdrin[1][3]); else n_pass++;
        n_checks++; if (lmdrl[2][4] !== 1'b1 || lmdrl[2][3] !== 1'b0) $display("FAIL read_lat2_load: c3=%b c4=%b required 0/1", lmdrl[2][3], lmdrl[2][4]); else n_pass++;
    endtask

    task automatic test_fetch;
        start(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0000_0006, 9);
        n_checks++; if (lreq[1][1] !== 1'b1 || laddr[1][1] !== 16'd1 || lwren[1][1] !== 1'b0) $display("FAIL fetch_req: req=%b addr=%h wren=%b required 1/0001/0", lreq[1][1], laddr[1][1], lwren[1][1]); else n_pass++;
        n_checks++; if (lmbrl[1][3] !== 1'b1 || lmbrin[1][3] !== 8'hCA) $display("FAIL fetch_mbr: load=%b mbr=%h required 1/ca", lmbrl[1][3], lmbrin[1][3]); else n_pass++;
        n_checks++; if (lmdrl[1][3] !== 1'b0 || lmbrl[1][2] !== 1'b0) $display("FAIL fetch_strobes: mdr_load=%b early mbr_load=%b required 0/0", lmdrl[1][3], lmbrl[1][2]); else n_pass++;
    endtask

    task automatic test_read_fetch;
        logic [7:0] st;
        start(1'b1, 1'b0, 1'b1, 32'h0000_0005, 32'h0, 32'h0000_0006, 9);
        n_checks++; if (lreq[2][1] !== 1'b1 || laddr[2][1] !== 16'd5) $display("FAIL rf_data_req: req=%b addr=%h required 1/0005", lreq[2][1], laddr[2][1]); else n_pass++;
        n_checks++; if ({lreq[2][2], lreq[2][3], lreq[2][4], lreq[2][5]} !== 4'b0010 || laddr[2][4] !== 16'd1) $display("FAIL rf_fetch_req: c2..5=%b addr=%h required 0010/0001", {lreq[2][2], lreq[2][3], lreq[2][4], lreq[2][5]}, laddr[2][4]); else n_pass++;
        n_checks++; if (lmdrl[2][4] !== 1'b1 || lmdrin[2][4] !== 32'h33) $display("FAIL rf_mdr: load=%b mdr=%h required 1/00000033", lmdrl[2][4], lmdrin[2][4]); else n_pass++;
        n_checks++; if (lmbrl[2][7] !== 1'b1 || lmbrin[2][7] !== 8'hCA || lmbrl[2][6] !== 1'b0) $display("FAIL rf_mbr: c6=%b c7=%b mbr=%h required 0/1/ca", lmbrl[2][6], lmbrl[2][7], lmbrin[2][7]); else n_pass++;
        for (int c = 1; c <= 8; c++) st[c-1] = lstall[2][c];
        n_checks++; if (st !== 8'b0011_1111) $display("FAIL rf_stall: c8..1=%b required 00111111", st); else n_pass++;
    endtask

    task automatic test_write;
        start(1'b0, 1'b1, 1'b0, 32'h0001_0003, 32'hDEAD_BEEF, 32'h0, 9);
        n_checks++; if (lreq[1][1] !== 1'b1 || lwren[1][1] !== 1'b1 || laddr[1][1] !== 16'h0003) $display("FAIL write_req: req=%b wren=%b addr=%h required 1/1/0003", lreq[1][1], lwren[1][1], laddr[1][1]); else n_pass++;
        n_checks++; if (lstall[1][1] !== 1'b1 || lstall[1][2] !== 1'b0 || lreq[1][2] !== 1'b0) $display("FAIL write_stall: c1=%b c2=%b req_c2=%b required 1/0/0", lstall[1][1], lstall[1][2], lreq[1][2]); else n_pass++;
        start(1'b1, 1'b0, 1'b0, 32'h0000_0003, 32'h0, 32'h0, 9);
        n_checks++; if (lmdrl[1][3] !== 1'b1 || lmdrin[1][3] !== 32'hDEAD_BEEF) $display("FAIL write_readback: load=%b mdr=%h required 1/deadbeef", lmdrl[1][3], lmdrin[1][3]); else n_pass++;
    endtask

    task automatic test_rd_wr_err;
        logic any_load;
        start(1'b1, 1'b1, 1'b0, 32'h0000_0007, 32'h1234_5678, 32'h0, 9);
        n_checks++; if (lerr[1][1] !== 1'b1 || lerr[1][2] !== 1'b0) $display("FAIL err_pulse: c1=%b c2=%b required 1/0", lerr[1][1], lerr[1][2]); else n_pass++;
        n_checks++; if (lwren[1][1] !== 1'b1 || lstall[1][2] !== 1'b0) $display("FAIL err_write_only: wren=%b stall_c2=%b required 1/0", lwren[1][1], lstall[1][2]); else n_pass++;
        any_load = 1'b0;
        for (int c = 1; c <= 9; c++) any_load = any_load | lmdrl[1][c];
        n_checks++; if (any_load !== 1'b0) $display("FAIL err_no_mdr_load: got %b required 0", any_load); else n_pass++;
        n_checks++; if (mem1[7] !== 32'h1234_5678) $display("FAIL err_mem: word7=%h required 12345678", mem1[7]); else n_pass++;
    endtask

    task automatic test_back_to_back;
        @(negedge clock);
        rd = 1'b1; mar = 32'h5;
        @(posedge clock);
        #1 rd = 1'b0;
        repeat (3) @(negedge clock);
        n_checks++; if (mdrl1 !== 1'b1 || stall1 !== 1'b0) $display("FAIL b2b_gap: mdr_load=%b stall=%b required 1/0", mdrl1, stall1); else n_pass++;
        fetch = 1'b1; pc = 32'h4;
        @(posedge clock);
        #1 fetch = 1'b0;
        @(negedge clock);
        n_checks++; if (req1 !== 1'b1 || addr1 !== 16'd1) $display("FAIL b2b_issue: req=%b addr=%h required 1/0001", req1, addr1); else n_pass++;
        repeat (2) @(negedge clock);
        n_checks++; if (mbrl1 !== 1'b1 || mbrin1 !== 8'h33) $display("FAIL b2b_mbr: load=%b mbr=%h required 1/33", mbrl1, mbrin1); else n_pass++;
        repeat (6) @(negedge clock);
        $display("txn back-to-back read then fetch");
    endtask

    task automatic test_reset_mid_access;
        logic any_act;
        @(negedge clock);
        rd = 1'b1; fetch = 1'b1; mar = 32'h5; pc = 32'h6;
        @(posedge clock);
        #1 rd = 1'b0; fetch = 1'b0;
        repeat (2) @(negedge clock);
        n_checks++; if (stall2 !== 1'b1) $display("FAIL rst_pre_stall: got %b required 1", stall2); else n_pass++;
        reset = 1'b1;
        #1;
        n_checks++; if ({stall2, req2, mdrl2, mbrl2, err2, mdrin2, addr2} !== '0) $display("FAIL rst_async: outputs=%h required 0", {stall2, req2, mdrl2, mbrl2, err2, mdrin2, addr2}); else n_pass++;
        @(negedge clock);
        reset = 1'b0;
        any_act = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            any_act = any_act | stall2 | req2 | mdrl2 | mbrl2;
        end
        n_checks++; if (any_act !== 1'b0) $display("FAIL rst_no_resume: activity=%b required 0", any_act); else n_pass++;
        $display("txn reset during D_WAIT");
        start(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0000_0006, 9);
        n_checks++; if (lmbrl[2][4] !== 1'b1 || lmbrin[2][4] !== 8'hCA) $display("FAIL rst_then_fetch: load=%b mbr=%h required 1/ca", lmbrl[2][4], lmbrin[2][4]); else n_pass++;
    endtask

    initial begin
        test_reset;
        test_read;
        test_fetch;
        test_read_fetch;
        test_write;
        test_rd_wr_err;
        test_back_to_back;
        test_reset_mid_access;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
